link_slave_fsm: RTL and testbench

LINK_SLAVE_FSM -- requirements
Module: link_slave_fsm

---
 rtl/link_slave_fsm.sv | 132 +++++++++++++
 tb/tb_link_slave_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/link_slave_fsm.sv
// Byte-serial link slave: assembles four big-endian bytes into a word, one ack per byte.
// Optional per-word XOR checksum when LINK_SLAVE_CHECKSUM_EN is defined.
module link_slave_fsm #(
    parameter int unsigned ACK_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [7:0]  data,
    output logic        ack,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  chk,
    output logic [7:0]  frame_cnt,
    output logic        proto_err
);

    typedef enum logic [1:0] {StIdle, StStall, StAck} state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic        load;
    logic        free;
    logic        hold_done;

    assign free      = !word_valid_q || word_ready;
    assign hold_done = hold_q >= 4'(ACK_HOLD - 1);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hold_d      = hold_q;
        buf_d       = buf_q;
        word_d      = word_q;
        proto_err_d = proto_err_q;
        load        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    unique case (byte_cnt_q)
                        2'd0: buf_d[31:24] = data;
                        2'd1: buf_d[23:16] = data;
                        2'd2: buf_d[15:8]  = data;
                        2'd3: buf_d[7:0]   = data;
                        default: ;
                    endcase
                    if (byte_cnt_q == 2'd3 && !free) begin
                        state_d = StStall;
                    end else begin
                        if (byte_cnt_q == 2'd3) begin
                            load   = 1'b1;
                            word_d = {buf_q[31:8], data};
                        end
                        state_d    = StAck;
                        hold_d     = 4'd0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StStall: begin
                if (req) proto_err_d = 1'b1;
                if (free) begin
                    load       = 1'b1;
                    word_d     = buf_q;
                    state_d    = StAck;
                    hold_d     = 4'd0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            StAck: begin
                if (hold_done) begin
                    if (req) proto_err_d = 1'b1;
                    else     state_d = StIdle;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A load wins over a same-cycle consume, so the new word stays valid.
    assign word_valid_d = load ? 1'b1 : (word_ready ? 1'b0 : word_valid_q);
    assign frame_cnt_d  = frame_cnt_q + {7'd0, load};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            byte_cnt_q   <= 2'd0;
            hold_q       <= 4'd0;
            buf_q        <= 32'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            hold_q       <= hold_d;
            buf_q        <= buf_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

`ifdef LINK_SLAVE_CHECKSUM_EN
    logic [7:0] chk_q;
    always_ff @(posedge clk) begin
        if (rst)       chk_q <= 8'd0;
        else if (load) chk_q <= word_d[31:24] ^ word_d[23:16] ^ word_d[15:8] ^ word_d[7:0];
    end
    assign chk = chk_q;
`else
    assign chk = 8'd0;
`endif

    assign ack        = (state_q == StAck);
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign frame_cnt  = frame_cnt_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_link_slave_fsm.sv
// Directed bench for link_slave_fsm: one instance with ACK_HOLD=1, one with ACK_HOLD=4.
module tb_link_slave_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        word_ready = 1'b1;
    logic        ack, word_valid, proto_err;
    logic [31:0] word;
    logic [7:0]  chk, frame_cnt;

    logic        req4 = 1'b0;
    logic [7:0]  data4 = 8'd0;
    logic        ack4, word_valid4, proto_err4;
    logic [31:0] word4;
    logic [7:0]  chk4, frame_cnt4;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    link_slave_fsm #(.ACK_HOLD(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .word(word),
        .word_valid(word_valid), .word_ready(word_ready), .chk(chk),
        .frame_cnt(frame_cnt), .proto_err(proto_err)
    );

    link_slave_fsm #(.ACK_HOLD(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .data(data4), .ack(ack4), .word(word4),
        .word_valid(word_valid4), .word_ready(1'b1), .chk(chk4),
        .frame_cnt(frame_cnt4), .proto_err(proto_err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Single-cycle req pulse, then wait (bounded) until ack has dropped.
    task automatic send_byte(input logic [7:0] d);
        int n;
        @(negedge clk);
        req  = 1'b1;
        data = d;
        @(negedge clk);
        req  = 1'b0;
        n    = 0;
        while (ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ack_timeout", 32'(ack), 32'd0);
    endtask

    logic [7:0] exp_chk;
    int         ack_cycles;

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_word", word, 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_frame", 32'(frame_cnt), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_chk", 32'(chk), 32'd0);

        // ACK_HOLD=4: single pulse gives exactly four ack cycles
        req4  = 1'b1;
        data4 = 8'h5A;
        @(negedge clk);
        req4 = 1'b0;
        ack_cycles = 0;
        while (ack4 && ack_cycles < 20) begin
            ack_cycles++;
            @(negedge clk);
        end
        check("hold4_cycles", 32'(ack_cycles), 32'd4);
        check("hold4_ack_low", 32'(ack4), 32'd0);
        check("hold4_byte_cnt", 32'(u_dut4.byte_cnt_q), 32'd1);
        check("hold4_perr", 32'(proto_err4), 32'd0);

        // Basic frame 12 34 56 78
        word_ready = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        @(negedge clk);
        req  = 1'b1;
        data = 8'h78;
        @(negedge clk);
        req = 1'b0;
`ifdef LINK_SLAVE_CHECKSUM_EN
        exp_chk = 8'h08;
`else
        exp_chk = 8'h00;
`endif
        check("f1_ack", 32'(ack), 32'd1);
        check("f1_valid", 32'(word_valid), 32'd1);
        check("f1_word", word, 32'h12345678);
        check("f1_chk", 32'(chk), 32'(exp_chk));
        check("f1_frame", 32'(frame_cnt), 32'd1);
        @(negedge clk);
        check("f1_valid_pulse", 32'(word_valid), 32'd0);
        check("f1_ack_drop", 32'(ack), 32'd0);

        // Backpressure: second frame stalls behind unconsumed first
        do_reset();
        word_ready = 1'b0;
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        @(negedge clk);
        check("st_ack", 32'(ack), 32'd0);
        check("st_word", word, 32'hA0A1A2A3);
        check("st_valid", 32'(word_valid), 32'd1);
        check("st_frame", 32'(frame_cnt), 32'd1);
        word_ready = 1'b1;
        @(negedge clk);
        check("st_ack_rise", 32'(ack), 32'd1);
        check("st_word_b", word, 32'hB0B1B2B3);
        check("st_valid_b", 32'(word_valid), 32'd1);
        check("st_frame_b", 32'(frame_cnt), 32'd2);
        @(negedge clk);
        check("st_valid_clr", 32'(word_valid), 32'd0);
        check("st_perr", 32'(proto_err), 32'd0);

        // Reset mid-frame discards partial bytes
        do_reset();
        send_byte(8'hDE);
        send_byte(8'hAD);
        do_reset();
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        check("rm_word", word, 32'hC0C1C2C3);
        check("rm_frame", 32'(frame_cnt), 32'd1);

        // 256 frames wrap frame_cnt
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int b = 0; b < 4; b++) send_byte(8'(f + b));
            if (f == 254) check("wrap_255", 32'(frame_cnt), 32'd255);
        end
        check("wrap_0", 32'(frame_cnt), 32'd0);
        check("wrap_word", word, 32'hFF000102);
        check("wrap_perr", 32'(proto_err), 32'd0);

        // ACK_HOLD=1 with req held three cycles
        do_reset();
        @(negedge clk);
        req  = 1'b1;
        data = 8'h11;
        repeat (3) @(negedge clk);
        req = 1'b0;
        check("perr_set", 32'(proto_err), 32'd1);
        repeat (5) @(negedge clk);
        check("perr_sticky", 32'(proto_err), 32'd1);
        do_reset();
        @(negedge clk);
        check("perr_rst", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
